// File: rtl/lsu_ahb_adapter_pkg.sv
// -----------------------------------------------------------------------------
// lsu_ahb_adapter_pkg
//   Shared definitions for the LSU-to-AHB word-port adapter:
//   - LSU access size encodings (byte / half / word / illegal)
//   - adapter FSM state enum
//   - default bus-wait timeout and counter width
//   - lsu_access_bad(): size/alignment legality check for an LSU request
// -----------------------------------------------------------------------------
package lsu_ahb_adapter_pkg;

    localparam logic [1:0] LSU_SIZE_B = 2'd0;
    localparam logic [1:0] LSU_SIZE_H = 2'd1;
    localparam logic [1:0] LSU_SIZE_W = 2'd2;
    localparam logic [1:0] LSU_SIZE_X = 2'd3;

    localparam int unsigned TIMEOUT_DEFAULT = 1023;
    localparam int unsigned TO_W_DEFAULT    = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_RSP     = 3'd5
    } adapter_state_e;

    // An access is rejected when its size is illegal or it is not naturally
    // aligned for that size.
    function automatic logic lsu_access_bad(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
        logic bad;
        case (size)
            LSU_SIZE_B: bad = 1'b0;
            LSU_SIZE_H: bad = addr_lo[0];
            LSU_SIZE_W: bad = |addr_lo;
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_ahb_adapter_if.sv
// -----------------------------------------------------------------------------
// lsu_ahb_adapter_if
//   Handshake bundles around the adapter.
//   lsu_if  : core LSU request/response channel.
//             master = LSU, slave = adapter.
//   ahbm_if : word-access request/response channel into the AHB subsystem.
//             master = adapter, slave = AHB fabric.
//   Each request and response channel is a valid/ready pair; a transfer
//   happens on a clock edge where both are high.
// -----------------------------------------------------------------------------
interface lsu_if;
    logic        req_vld;
    logic        req_rdy;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_vld, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_rdy,
        input  req_rdy, rsp_vld, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_vld, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_rdy,
        output req_rdy, rsp_vld, rsp_rdata, rsp_err
    );
endinterface

interface ahbm_if;
    logic        req_vld;
    logic        req_rdy;
    logic        req_wen;
    logic        req_rwtyp;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_rdata;

    modport master (
        output req_vld, req_wen, req_rwtyp, req_addr, req_wdata, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_rdata
    );

    modport slave (
        input  req_vld, req_wen, req_rwtyp, req_addr, req_wdata, rsp_rdy,
        output req_rdy, rsp_vld, rsp_rdata
    );
endinterface

// File: rtl/lsu_ahb_adapter_lane_unit.sv
// -----------------------------------------------------------------------------
// lsu_lane_unit
//   Purely combinational lane logic for sub-word accesses.
//   Ports:
//     size        in  2   access size (byte / half / word)
//     is_unsigned in  1   zero-extend instead of sign-extend loads
//     byte_off    in  2   addr[1:0] of the access
//     bus_word    in  32  full word read from the bus
//     st_data     in  32  right-aligned store data
//     ld_data     out 32  selected lane, extended to 32 bits
//     st_word     out 32  bus_word with the addressed lane replaced by st_data
// -----------------------------------------------------------------------------
module lsu_lane_unit
    import lsu_ahb_adapter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  byte_off,
    input  logic [31:0] bus_word,
    input  logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = bus_word[7:0];
        case (byte_off)
            2'd0: ld_byte = bus_word[7:0];
            2'd1: ld_byte = bus_word[15:8];
            2'd2: ld_byte = bus_word[23:16];
            2'd3: ld_byte = bus_word[31:24];
        endcase
        // Halfwords are 2-byte aligned, so only addr[1] picks the lane.
        ld_half = byte_off[1] ? bus_word[31:16] : bus_word[15:0];

        case (size)
            LSU_SIZE_B: ld_data = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
            LSU_SIZE_H: ld_data = {{16{~is_unsigned & ld_half[15]}}, ld_half};
            default:    ld_data = bus_word;
        endcase

        st_word = bus_word;
        case (size)
            LSU_SIZE_B: begin
                case (byte_off)
                    2'd0: st_word[7:0]   = st_data[7:0];
                    2'd1: st_word[15:8]  = st_data[7:0];
                    2'd2: st_word[23:16] = st_data[7:0];
                    2'd3: st_word[31:24] = st_data[7:0];
                endcase
            end
            LSU_SIZE_H: begin
                if (byte_off[1]) begin
                    st_word[31:16] = st_data[15:0];
                end else begin
                    st_word[15:0] = st_data[15:0];
                end
            end
            default: st_word = st_data;
        endcase
    end

endmodule

// File: rtl/lsu_ahb_adapter.sv
// -----------------------------------------------------------------------------
// lsu_ahb_adapter
//   Converts RISC-V byte/half/word loads and stores from the core LSU into
//   word-aligned transactions on the ahbm_lsu_* word port. Sub-word loads are
//   lane-extracted and extended; sub-word stores are read-modify-write.
//   Misaligned or illegal-size requests are answered with an error and no bus
//   traffic. Every bus wait is bounded by TIMEOUT cycles (0 = unbounded).
//   Ports:
//     clk   in   system clock
//     rstn  in   asynchronous active-low reset
//     lsu   slave  modport of lsu_if  (LSU request / response)
//     ahbm  master modport of ahbm_if (bus request / response)
//   Parameters:
//     TIMEOUT  max wait cycles for a bus response, 0 disables the timeout
//     TO_W     timeout counter width, 2**TO_W > TIMEOUT
// -----------------------------------------------------------------------------
module lsu_ahb_adapter
    import lsu_ahb_adapter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned TO_W    = TO_W_DEFAULT
) (
    input  logic   clk,
    input  logic   rstn,
    lsu_if.slave   lsu,
    ahbm_if.master ahbm
);

    localparam bit            TO_EN   = (TIMEOUT != 0);
    // The timeout fires at the end of the TIMEOUT-th cycle spent in a wait
    // state; the counter holds 0 in the first wait cycle.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    adapter_state_e  state_q, state_d;
    logic            drain_q, drain_d;
    logic            wen_q, wen_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    logic            req_rdy;
    logic            in_wait;
    logic            to_fire;
    logic [31:0]     ld_data;
    logic [31:0]     st_word;

    assign req_rdy = (state_q == ST_IDLE) && !drain_q;
    assign in_wait = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
    assign to_fire = TO_EN && (cnt_q == TO_LAST);

    lsu_lane_unit u_lane (
        .size        (size_q),
        .is_unsigned (uns_q),
        .byte_off    (addr_q[1:0]),
        .bus_word    (ahbm.rsp_rdata),
        .st_data     (wdata_q),
        .ld_data     (ld_data),
        .st_word     (st_word)
    );

    // Next-state, datapath capture and timeout counter
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        wen_d   = wen_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        // Counter is zero outside the wait states, so each wait starts at 0.
        cnt_d   = '0;

        // A late bus response after a timeout is swallowed here.
        if (drain_q && ahbm.rsp_vld) begin
            drain_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (lsu.req_vld && req_rdy) begin
                    wen_d   = lsu.req_wen;
                    size_d  = lsu.req_size;
                    uns_d   = lsu.req_unsigned;
                    addr_d  = lsu.req_addr;
                    wdata_d = lsu.req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (lsu_access_bad(lsu.req_size, lsu.req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_RSP;
                    end else if (lsu.req_wen && (lsu.req_size == LSU_SIZE_W)) begin
                        state_d = ST_WR_REQ;
                    end else begin
                        // Loads and sub-word stores both start with a read.
                        state_d = ST_RD_REQ;
                    end
                end
            end

            ST_RD_REQ: begin
                if (ahbm.req_rdy) begin
                    state_d = ST_RD_WAIT;
                end
            end

            ST_WR_REQ: begin
                if (ahbm.req_rdy) begin
                    state_d = ST_WR_WAIT;
                end
            end

            ST_RD_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A response in the timeout cycle still wins.
                if (ahbm.rsp_vld) begin
                    if (wen_q) begin
                        wdata_d = st_word;
                        state_d = ST_WR_REQ;
                    end else begin
                        rdata_d = ld_data;
                        state_d = ST_RSP;
                    end
                end else if (to_fire) begin
                    err_d   = 1'b1;
                    drain_d = 1'b1;
                    state_d = ST_RSP;
                end
            end

            ST_WR_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (ahbm.rsp_vld) begin
                    rdata_d = '0;
                    state_d = ST_RSP;
                end else if (to_fire) begin
                    err_d   = 1'b1;
                    drain_d = 1'b1;
                    state_d = ST_RSP;
                end
            end

            ST_RSP: begin
                if (lsu.rsp_rdy) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            drain_q <= 1'b0;
            wen_q   <= 1'b0;
            size_q  <= LSU_SIZE_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs, all decoded from registers
    assign lsu.req_rdy   = req_rdy;
    assign lsu.rsp_vld   = (state_q == ST_RSP);
    assign lsu.rsp_rdata = rdata_q;
    assign lsu.rsp_err   = err_q;

    assign ahbm.req_vld   = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
    assign ahbm.req_wen   = (state_q == ST_WR_REQ);
    assign ahbm.req_rwtyp = 1'b1;
    assign ahbm.req_addr  = {addr_q[31:2], 2'b00};
    assign ahbm.req_wdata = wdata_q;
    assign ahbm.rsp_rdy   = in_wait || drain_q;

`ifndef SYNTHESIS
    // The fabric may only respond while a response is expected.
    rsp_in_window_a : assert property (@(posedge clk) disable iff (!rstn)
        ahbm.rsp_vld |-> (in_wait || drain_q));
`endif

endmodule

// File: tb/tb_lsu_ahb_adapter.sv
module tb_lsu_ahb_adapter;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    lsu_if  lsu_b ();
    ahbm_if ahb_b ();

    lsu_ahb_adapter #(.TIMEOUT(TO), .TO_W(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .lsu  (lsu_b.slave),
        .ahbm (ahb_b.master)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        int          nb;
        beat_t       b0;
        beat_t       b1;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        int          viol;
        bit          done;
    } res_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          nb;
        beat_t       b0;
        beat_t       b1;
    } exp_t;

    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_nb;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        int          exp_cyc;
    } tv_t;

    tv_t tv[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return {25'd0, lsu_b.req_rdy, lsu_b.rsp_vld, lsu_b.rsp_rdata, lsu_b.rsp_err,
                ahb_b.req_vld, ahb_b.req_wen, ahb_b.req_rwtyp, ahb_b.req_addr,
                ahb_b.req_wdata, ahb_b.rsp_rdy};
    endfunction

    localparam logic [127:0] RESET_OUTS =
        {25'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};

    // Reference model: what one LSU access should look like on both sides,
    // computed from shifts and masks on the addressed lane.
    function automatic void model(input logic wen, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] mem, output exp_t e);
        logic [31:0] mask, val, aligned;
        int sh;
        e.err = 1'b0; e.rdata = '0; e.nb = 0; e.b0 = '0; e.b1 = '0;
        if (size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0)) begin
            e.err = 1'b1;
            return;
        end
        sh      = 8 * int'(addr[1:0]);
        mask    = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        aligned = addr & ~32'h3;
        if (!wen) begin
            val = (mem >> sh) & mask;
            if (!uns && size != 2'd2 && ((val & ~(mask >> 1)) != 0)) val = val | ~mask;
            e.rdata = val;
            e.nb    = 1;
            e.b0    = {1'b0, aligned, 32'h0};
        end else if (size == 2'd2) begin
            e.nb = 1;
            e.b0 = {1'b1, aligned, wdata};
        end else begin
            e.nb = 2;
            e.b0 = {1'b0, aligned, 32'h0};
            e.b1 = {1'b1, aligned, (mem & ~(mask << sh)) | ((wdata & mask) << sh)};
        end
    endfunction

    // Issues one LSU request and plays the bus fabric and the LSU response
    // side cycle by cycle. rsp_dly = cycles from bus request handshake to the
    // bus response (0 = never respond). Cycle 1 is the first cycle after the
    // accept edge.
    task automatic run_op(input logic wen, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] mem, input int req_stall,
                          input int rsp_dly, input int lsu_stall, output res_t r);
        int    cyc, guard, stall_left, wait_n, hold_left;
        bit    beat_open, rsp_seen, wait_wr;
        beat_t cur;
        beat_t ref_b;
        r.nb = 0; r.b0 = '0; r.b1 = '0; r.rdata = '0; r.err = 1'b0;
        r.cyc = -1; r.viol = 0; r.done = 1'b0;
        ref_b = '0;
        lsu_b.req_wen      = wen;
        lsu_b.req_size     = size;
        lsu_b.req_unsigned = uns;
        lsu_b.req_addr     = addr;
        lsu_b.req_wdata    = wdata;
        lsu_b.req_vld      = 1'b1;
        guard = 0;
        while (!lsu_b.req_rdy && guard < 50) begin
            tick();
            guard++;
        end
        if (!lsu_b.req_rdy) begin
            lsu_b.req_vld = 1'b0;
            return;
        end
        tick();
        lsu_b.req_vld = 1'b0;
        cyc = 1; beat_open = 0; rsp_seen = 0; wait_n = 0; wait_wr = 0;
        hold_left = lsu_stall; stall_left = 0;
        while (!r.done && cyc < 200) begin
            ahb_b.req_rdy   = 1'b0;
            ahb_b.rsp_vld   = 1'b0;
            ahb_b.rsp_rdata = $urandom;
            lsu_b.rsp_rdy   = 1'b0;
            if (lsu_b.req_rdy) r.viol++;
            if (wait_n > 0) begin
                wait_n--;
                if (wait_n == 0) begin
                    ahb_b.rsp_vld = 1'b1;
                    if (!wait_wr) ahb_b.rsp_rdata = mem;
                end
            end
            if (ahb_b.req_vld) begin
                cur = {ahb_b.req_wen, ahb_b.req_addr, ahb_b.req_wdata};
                if (!beat_open) begin
                    beat_open  = 1;
                    ref_b      = cur;
                    stall_left = req_stall;
                end else if (cur != ref_b) begin
                    r.viol++;
                end
                if (ahb_b.req_rwtyp !== 1'b1) r.viol++;
                if (stall_left == 0) begin
                    ahb_b.req_rdy = 1'b1;
                    beat_open = 0;
                    if (r.nb == 0) r.b0 = ref_b; else r.b1 = ref_b;
                    r.nb++;
                    wait_n  = rsp_dly;
                    wait_wr = ref_b.wen;
                end else begin
                    stall_left--;
                end
            end
            if (lsu_b.rsp_vld) begin
                if (!rsp_seen) begin
                    rsp_seen = 1;
                    r.cyc    = cyc;
                    r.rdata  = lsu_b.rsp_rdata;
                    r.err    = lsu_b.rsp_err;
                end else if (r.rdata !== lsu_b.rsp_rdata || r.err !== lsu_b.rsp_err) begin
                    r.viol++;
                end
                if (hold_left == 0) begin
                    lsu_b.rsp_rdy = 1'b1;
                    r.done = 1'b1;
                end else begin
                    hold_left--;
                end
            end
            tick();
            cyc++;
        end
        ahb_b.req_rdy = 1'b0;
        ahb_b.rsp_vld = 1'b0;
        lsu_b.rsp_rdy = 1'b0;
    endtask

    task automatic chk_model(input string tag, input res_t r, input exp_t e);
        chk({tag, "_done"}, r.done, 1'b1);
        chk({tag, "_rdata"}, r.rdata, e.rdata);
        chk({tag, "_err"}, r.err, e.err);
        chk({tag, "_nbeats"}, r.nb, e.nb);
        if (e.nb > 0) begin
            chk({tag, "_b0_wen"}, r.b0.wen, e.b0.wen);
            chk({tag, "_b0_addr"}, r.b0.addr, e.b0.addr);
            if (e.b0.wen) chk({tag, "_b0_wdata"}, r.b0.wdata, e.b0.wdata);
        end
        if (e.nb > 1) begin
            chk({tag, "_b1_wen"}, r.b1.wen, e.b1.wen);
            chk({tag, "_b1_addr"}, r.b1.addr, e.b1.addr);
            chk({tag, "_b1_wdata"}, r.b1.wdata, e.b1.wdata);
        end
        chk({tag, "_protocol"}, r.viol, 0);
    endtask

    initial begin
        res_t  r;
        exp_t  e;
        beat_t last;

        //        wen   size   uns   addr          wdata          mem            exp_rdata      err  nb addr          wdata          cyc
        tv[0]  = '{1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0,         32'h80FF_1234, 32'hFFFF_FF80, 1'b0, 1, 32'h0000_1000, 32'h0,         3};
        tv[1]  = '{1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0,         32'h80FF_1234, 32'h0000_0080, 1'b0, 1, 32'h0000_1000, 32'h0,         3};
        tv[2]  = '{1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 32'h1122_3344, 32'h0,         1'b0, 2, 32'h0000_2000, 32'hBEEF_3344, 5};
        tv[3]  = '{1'b1, 2'd2, 1'b0, 32'h0000_2001, 32'h1234_5678, 32'h0,         32'h0,         1'b1, 0, 32'h0,         32'h0,         1};
        tv[4]  = '{1'b0, 2'd3, 1'b0, 32'h0000_2000, 32'h0,         32'h0,         32'h0,         1'b1, 0, 32'h0,         32'h0,         1};
        tv[5]  = '{1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1, 32'h0000_3000, 32'h0,         3};
        tv[6]  = '{1'b0, 2'd1, 1'b0, 32'h0000_1002, 32'h0,         32'h80FF_1234, 32'hFFFF_80FF, 1'b0, 1, 32'h0000_1000, 32'h0,         3};
        tv[7]  = '{1'b0, 2'd1, 1'b1, 32'h0000_1000, 32'h0,         32'h80FF_1234, 32'h0000_1234, 1'b0, 1, 32'h0000_1000, 32'h0,         3};
        tv[8]  = '{1'b0, 2'd1, 1'b0, 32'h0000_1001, 32'h0,         32'h80FF_1234, 32'h0,         1'b1, 0, 32'h0,         32'h0,         1};
        tv[9]  = '{1'b1, 2'd0, 1'b0, 32'h0000_4001, 32'h0000_00AA, 32'h1122_3344, 32'h0,         1'b0, 2, 32'h0000_4000, 32'h1122_AA44, 5};
        tv[10] = '{1'b1, 2'd2, 1'b0, 32'h0000_5000, 32'hCAFE_F00D, 32'h0,         32'h0,         1'b0, 1, 32'h0000_5000, 32'hCAFE_F00D, 3};
        tv[11] = '{1'b0, 2'd0, 1'b0, 32'h0000_1000, 32'h0,         32'h80FF_1234, 32'h0000_0034, 1'b0, 1, 32'h0000_1000, 32'h0,         3};
        tv[12] = '{1'b1, 2'd0, 1'b0, 32'h0000_4003, 32'hFFFF_FF55, 32'h1122_3344, 32'h0,         1'b0, 2, 32'h0000_4000, 32'h5522_3344, 5};

        lsu_b.req_vld = 1'b0; lsu_b.req_wen = 1'b0; lsu_b.req_size = 2'd0;
        lsu_b.req_unsigned = 1'b0; lsu_b.req_addr = '0; lsu_b.req_wdata = '0;
        lsu_b.rsp_rdy = 1'b0;
        ahb_b.req_rdy = 1'b0; ahb_b.rsp_vld = 1'b0; ahb_b.rsp_rdata = '0;

        // Reset state
        rstn = 1'b0;
        tick();
        tick();
        chk("reset_outputs", outs(), RESET_OUTS);
        rstn = 1'b1;
        tick();
        chk("post_reset_outputs", outs(), RESET_OUTS);

        // Directed table, always-ready bus, 1-cycle response
        for (int i = 0; i < 13; i++) begin
            run_op(tv[i].wen, tv[i].size, tv[i].uns, tv[i].addr, tv[i].wdata, tv[i].mem, 0, 1, 0, r);
            chk($sformatf("tv%0d_done", i), r.done, 1'b1);
            chk($sformatf("tv%0d_rdata", i), r.rdata, tv[i].exp_rdata);
            chk($sformatf("tv%0d_err", i), r.err, tv[i].exp_err);
            chk($sformatf("tv%0d_nbeats", i), r.nb, tv[i].exp_nb);
            chk($sformatf("tv%0d_latency", i), r.cyc, tv[i].exp_cyc);
            if (tv[i].exp_nb > 0) begin
                last = (r.nb > 1) ? r.b1 : r.b0;
                chk($sformatf("tv%0d_addr", i), last.addr, tv[i].exp_addr);
                chk($sformatf("tv%0d_wen", i), last.wen, tv[i].wen);
                if (tv[i].wen) chk($sformatf("tv%0d_wdata", i), last.wdata, tv[i].exp_wdata);
            end
        end

        // Randomised accesses against the reference model
        for (int i = 0; i < 150; i++) begin
            logic        wen, uns;
            logic [1:0]  size;
            logic [31:0] addr, wdata, mem;
            wen   = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            addr  = $urandom;
            wdata = $urandom;
            mem   = $urandom;
            model(wen, size, uns, addr, wdata, mem, e);
            run_op(wen, size, uns, addr, wdata, mem, $urandom_range(0, 3),
                   $urandom_range(1, 5), $urandom_range(0, 3), r);
            chk_model($sformatf("rnd%0d", i), r, e);
        end

        // Bus and LSU back-pressure on a word load
        run_op(1'b0, 2'd2, 1'b0, 32'h0000_3004, 32'h0, 32'h0123_4567, 4, 2, 3, r);
        model(1'b0, 2'd2, 1'b0, 32'h0000_3004, 32'h0, 32'h0123_4567, e);
        chk_model("stall_lw", r, e);
        chk("stall_lw_latency", r.cyc, 8);

        // Response in the very cycle the timeout would fire: response wins
        run_op(1'b0, 2'd2, 1'b0, 32'h0000_3008, 32'h0, 32'h5A5A_0F0F, 0, TO, 0, r);
        chk("race_done", r.done, 1'b1);
        chk("race_rdata", r.rdata, 32'h5A5A_0F0F);
        chk("race_err", r.err, 1'b0);
        chk("race_latency", r.cyc, 2 + TO);
        chk("race_no_drain_rdy", lsu_b.req_rdy, 1'b1);
        chk("race_no_drain_rsp_rdy", ahb_b.rsp_rdy, 1'b0);

        // Bus never answers: timeout error after TO wait cycles, then drain
        run_op(1'b0, 2'd2, 1'b0, 32'h0000_300C, 32'h0, 32'h0, 0, 0, 0, r);
        chk("to_done", r.done, 1'b1);
        chk("to_err", r.err, 1'b1);
        chk("to_rdata", r.rdata, 32'h0);
        chk("to_latency", r.cyc, 2 + TO);
        chk("drain_req_rdy", lsu_b.req_rdy, 1'b0);
        chk("drain_rsp_rdy", ahb_b.rsp_rdy, 1'b1);
        lsu_b.req_wen = 1'b0; lsu_b.req_size = 2'd2; lsu_b.req_addr = 32'h0000_7000;
        lsu_b.req_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("drain_refuse%0d", k), lsu_b.req_rdy, 1'b0);
            chk($sformatf("drain_no_bus%0d", k), ahb_b.req_vld, 1'b0);
        end
        lsu_b.req_vld   = 1'b0;
        ahb_b.rsp_vld   = 1'b1;
        ahb_b.rsp_rdata = 32'hFFFF_FFFF;
        tick();
        ahb_b.rsp_vld = 1'b0;
        chk("drain_cleared_rdy", lsu_b.req_rdy, 1'b1);
        chk("drain_cleared_rsp_rdy", ahb_b.rsp_rdy, 1'b0);
        run_op(1'b0, 2'd2, 1'b0, 32'h0000_7000, 32'h0, 32'h2468_ACE0, 0, 1, 0, r);
        model(1'b0, 2'd2, 1'b0, 32'h0000_7000, 32'h0, 32'h2468_ACE0, e);
        chk_model("after_drain_lw", r, e);

        // Reset asserted while waiting for the bus read response
        lsu_b.req_wen = 1'b0; lsu_b.req_size = 2'd2; lsu_b.req_unsigned = 1'b0;
        lsu_b.req_addr = 32'h0000_6000; lsu_b.req_wdata = 32'h1357_9BDF;
        lsu_b.req_vld = 1'b1;
        tick();
        lsu_b.req_vld = 1'b0;
        chk("rst_mid_rdreq", ahb_b.req_vld, 1'b1);
        ahb_b.req_rdy = 1'b1;
        tick();
        ahb_b.req_rdy = 1'b0;
        chk("rst_mid_rdwait", ahb_b.rsp_rdy, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_mid_outputs", outs(), RESET_OUTS);
        tick();
        chk("rst_mid_held", outs(), RESET_OUTS);
        rstn = 1'b1;
        tick();
        run_op(1'b0, 2'd2, 1'b0, 32'h0000_6004, 32'h0, 32'h0BAD_F00D, 0, 1, 0, r);
        model(1'b0, 2'd2, 1'b0, 32'h0000_6004, 32'h0, 32'h0BAD_F00D, e);
        chk_model("after_rst_lw", r, e);
        chk("after_rst_latency", r.cyc, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_ahb_adapter.md
Name: lsu_ahb_adapter

Overview:
Sits directly upstream of ahb_lite_top, between the core LSU and the ahbm_lsu_* word-access port of the AHB subsystem. Converts RISC-V byte, halfword and word loads/stores into word-aligned bus transactions. Sub-word loads are lane-extracted and sign/zero-extended; sub-word stores are done as read-modify-write. Also detects misalignment and bounds every bus wait with a timeout.

Parameters:
TIMEOUT, 1023, max cycles to wait for a bus response (0 = wait forever)
TO_W, 10, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT

Ports:
clk  in  1  system clock
rstn  in  1  reset; one clock; reset is asynchronous and active-low
lsu_req_vld  in  1  LSU request valid
lsu_req_rdy  out  1  adapter can accept a request
lsu_req_wen  in  1  1 = store, 0 = load
lsu_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
lsu_req_unsigned  in  1  zero-extend the load result (LBU/LHU)
lsu_req_addr  in  32  byte address
lsu_req_wdata  in  32  store data, right-aligned
lsu_rsp_vld  out  1  response valid
lsu_rsp_rdy  in  1  LSU accepts the response
lsu_rsp_rdata  out  32  extended load data (0 for stores and errors)
lsu_rsp_err  out  1  misaligned access, illegal size, or timeout
ahbm_lsu_req_vld  out  1  bus request valid
ahbm_lsu_req_rdy  in  1  bus request ready
ahbm_lsu_req_wen  out  1  bus write enable
ahbm_lsu_req_rwtyp  out  1  constant 1 (word access)
ahbm_lsu_req_addr  out  32  {addr[31:2], 2'b00}
ahbm_lsu_req_wdata  out  32  full-word write data
ahbm_lsu_rsp_vld  in  1  bus response valid (one per request, including writes)
ahbm_lsu_rsp_rdy  out  1  adapter accepts the bus response
ahbm_lsu_rsp_rdata  in  32  bus read data

Behaviour:
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RSP. One LSU request in flight at a time.
- Reset values:
  - state = IDLE, drain = 0, so lsu_req_rdy = 1.
  - All other outputs 0; ahbm_lsu_req_rwtyp = 1.
- lsu_req_rdy = (state == IDLE) && !drain.
- On accept (vld && rdy), register wen, size, unsigned, addr and wdata, then branch:
  - size = 3, or half with addr[0] = 1, or word with addr[1:0] != 0 -> RSP with err = 1. No bus traffic.
  - load -> RD_REQ.
  - word store -> WR_REQ, with req_wdata = registered wdata.
  - byte/half store -> RD_REQ, then read-modify-write.
- RD_REQ / WR_REQ:
  - Assert ahbm_lsu_req_vld; address, wen and wdata are held stable while vld is high.
  - On ahbm_lsu_req_rdy, go to RD_WAIT / WR_WAIT.
- RD_WAIT / WR_WAIT:
  - ahbm_lsu_rsp_rdy = 1.
  - On ahbm_lsu_rsp_vld, RD_WAIT branches:
    - load: extract the lane selected by addr[1:0] (byte) or addr[1] (half), extend per unsigned -> RSP.
    - sub-word store: replace the byte/half lane of the read word with wdata[7:0] / wdata[15:0] -> WR_REQ.
  - On ahbm_lsu_rsp_vld in WR_WAIT -> RSP with rdata = 0.
- Timeout:
  - Counter clears on entry to each WAIT state and increments every cycle in a WAIT state.
  - When the counter reaches TIMEOUT (TIMEOUT != 0) before rsp_vld: go to RSP with err = 1 and set drain = 1.
- Drain: while drain = 1, ahbm_lsu_rsp_rdy = 1 and no new LSU request is accepted. The next bus rsp_vld is discarded and clears drain.
- RSP: lsu_rsp_vld = 1, with rdata/err held until lsu_rsp_rdy; then IDLE. Back-pressure of any length is allowed.
- Rsp_vld in the same cycle the timeout fires: the response wins; no timeout, no drain.
- ahbm_lsu_rsp_vld outside a WAIT state with drain = 0 is a protocol violation; flag it with an assertion only.
- Latency with an always-ready bus and a 1-cycle bus response: word load accept -> lsu_rsp_vld after 3 cycles; sub-word store after 5 cycles.
- Reset asserted mid-operation: immediate return to IDLE, drain cleared, all outputs at reset values. Any bus transaction in progress is abandoned; the fabric is reset by the same rstn.

Decomposition:
- Shared package (const_defines.svh): LSU_SIZE_B/H/W encodings, adapter FSM state enum, TIMEOUT default.
- One natural combinational sub-module: lsu_lane_unit. It does load lane extract + sign/zero extension and store lane merge, selected by size and addr[1:0].
- FSM, timeout counter and drain flag stay in lsu_ahb_adapter.

Test Plan:
- LB at 0x1003, bus returns 0x80FF_1234 -> rdata 0xFFFF_FF80, err 0; LBU -> 0x0000_0080; exactly one bus read to 0x1000.
- SH at 0x2002, wdata 0x0000_BEEF, bus read returns 0x1122_3344 -> bus write to 0x2000 with 0xBEEF_3344, then lsu rsp err 0.
- SW at 0x2001 -> lsu_rsp_err = 1 after 1 cycle, ahbm_lsu_req_vld never asserted; size = 3 gives the same result.
- Word load: bus holds req_rdy low 4 cycles and rsp after 2 cycles, LSU holds rsp_rdy low 3 cycles -> addr/vld stable throughout, rdata correct, lsu_req_rdy low until the response is taken.
- TIMEOUT = 8, bus never responds -> err = 1 on cycle 8 of the wait. A late rsp is swallowed, and a new LSU request is refused until it arrives.
- Assert rstn low during RD_WAIT -> all outputs 0 (lsu_req_rdy 1) immediately. A following LW completes normally.
